// File: rtl/filter2d_stream.sv
// Streaming 3x3 convolution over a raster image with zero padding, two line
// buffers, a three-stage pipeline (window, multiply, sum/saturate) and an end-of-frame flush.
module filter2d_stream #(
  parameter int DW    = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int SHIFT = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_strb,
  input  logic [DW-1:0]     i_data,
  input  logic              i_coef_we,
  input  logic [3:0]        i_coef_addr,
  input  logic signed [7:0] i_coef,
  output logic              o_busy,
  output logic              o_strb,
  output logic [DW-1:0]     o_data,
  output logic              o_eof,
  output logic              o_ovf
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 2);
  localparam int FW = $clog2(IMG_W + 2);
  localparam int PW = DW + 9;
  localparam int SW = DW + 13;
  localparam logic signed [7:0] C_RST = (SHIFT >= 7) ? 8'sd127 : 8'(2 ** SHIFT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [CW-1:0]   col_q, col_d, ocol_q, ocol_d;
  logic [RW-1:0]   row_q, row_d, orow_q, orow_d;
  logic            ovf_q;

  logic signed [7:0] shadow_q [9];
  logic signed [7:0] shadow_d [9];
  logic signed [7:0] active_q [9];

  logic [DW-1:0]   lb1_q [IMG_W];
  logic [DW-1:0]   lb2_q [IMG_W];
  logic [DW-1:0]   win_p0_q [9];
  logic [8:0]      mask_p0_q, mask_d;
  logic            vld_p0_q, eof_p0_q;
  logic signed [PW-1:0] prod_p1_q [9];
  logic            vld_p1_q, eof_p1_q;
  logic signed [SW-1:0] sum_p1;
  logic [DW-1:0]   data_p2_q;
  logic            vld_p2_q, eof_p2_q;

  logic            acc, flush_stb, stb, first_in, last_in, trig;
  logic [DW-1:0]   pix, tap_top, tap_mid;
  logic            t_row, b_row, l_col, r_col;

  function automatic logic signed [PW-1:0] mul(input logic [DW-1:0] p,
                                               input logic signed [7:0] c);
    logic signed [PW-1:0] pe;
    logic signed [PW-1:0] ce;
    pe  = $signed({9'b0, p});
    ce  = {{(PW-8){c[7]}}, c};
    mul = pe * ce;
  endfunction

  function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] sh;
    sh = s >>> SHIFT;
    if (sh[SW-1])            sat = '0;
    else if (|sh[SW-2:DW])   sat = '1;
    else                     sat = sh[DW-1:0];
  endfunction

  assign acc       = i_strb && (state_q != S_FLUSH);
  assign flush_stb = (state_q == S_FLUSH) && (fcnt_q < FW'(IMG_W + 1));
  assign stb       = acc || flush_stb;
  assign pix       = acc ? i_data : '0;
  assign first_in  = acc && (col_q == '0) && (row_q == '0);
  assign last_in   = acc && (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
  // An output exists once the window centre (one line and one pixel back) is inside the frame.
  assign trig      = stb && ((row_q > RW'(1)) || ((row_q == RW'(1)) && (col_q != '0)));
  assign tap_top   = lb2_q[col_q];
  assign tap_mid   = lb1_q[col_q];

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (last_in) begin
          state_d = S_FLUSH;
          fcnt_d  = '0;
        end else if (acc) begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (flush_stb) fcnt_d = fcnt_q + FW'(1);
        if (eof_p2_q)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    if ((state_q == S_FLUSH) && eof_p2_q) begin
      col_d = '0;
      row_d = '0;
    end else if (stb) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (trig) begin
      if (ocol_q == CW'(IMG_W - 1)) begin
        ocol_d = '0;
        orow_d = (orow_q == RW'(IMG_H - 1)) ? '0 : orow_q + RW'(1);
      end else begin
        ocol_d = ocol_q + CW'(1);
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (i_coef_we && (i_coef_addr < 4'd9)) shadow_d[i_coef_addr] = i_coef;
  end

  always_comb begin
    t_row = (orow_q == '0);
    b_row = (orow_q == RW'(IMG_H - 1));
    l_col = (ocol_q == '0);
    r_col = (ocol_q == CW'(IMG_W - 1));
    mask_d = '0;
    for (int k = 0; k < 9; k++) begin
      mask_d[k] = ((k < 3) && t_row) || ((k >= 6) && b_row) ||
                  ((k % 3 == 0) && l_col) || ((k % 3 == 2) && r_col);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        shadow_q[k] <= (k == 4) ? C_RST : 8'sd0;
        active_q[k] <= (k == 4) ? C_RST : 8'sd0;
      end
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      ocol_q   <= ocol_d;
      orow_q   <= orow_d;
      shadow_q <= shadow_d;
      if (first_in) active_q <= shadow_d;
      if (i_strb && (state_q == S_FLUSH)) ovf_q <= 1'b1;
    end
  end

  // Stage p0: line buffers and 3x3 window; right column is the newest.
  always_ff @(posedge clk) begin
    if (stb) begin
      lb2_q[col_q] <= tap_mid;
      lb1_q[col_q] <= pix;
      win_p0_q[0]  <= win_p0_q[1];
      win_p0_q[1]  <= win_p0_q[2];
      win_p0_q[2]  <= tap_top;
      win_p0_q[3]  <= win_p0_q[4];
      win_p0_q[4]  <= win_p0_q[5];
      win_p0_q[5]  <= tap_mid;
      win_p0_q[6]  <= win_p0_q[7];
      win_p0_q[7]  <= win_p0_q[8];
      win_p0_q[8]  <= pix;
      mask_p0_q    <= mask_d;
    end
  end

  // Stage p1: nine products, padding taps forced to zero.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 9; k++) begin
      prod_p1_q[k] <= mask_p0_q[k] ? '0 : mul(win_p0_q[k], active_q[k]);
    end
  end

  always_comb begin
    sum_p1 = '0;
    for (int k = 0; k < 9; k++) begin
      sum_p1 = sum_p1 + {{4{prod_p1_q[k][PW-1]}}, prod_p1_q[k]};
    end
  end

  // Stage p2: shift, saturate and register the outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vld_p0_q  <= 1'b0;
      eof_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      eof_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      eof_p2_q  <= 1'b0;
      data_p2_q <= '0;
    end else begin
      vld_p0_q <= trig;
      eof_p0_q <= trig && (ocol_q == CW'(IMG_W - 1)) && (orow_q == RW'(IMG_H - 1));
      vld_p1_q <= vld_p0_q;
      eof_p1_q <= eof_p0_q;
      vld_p2_q <= vld_p1_q;
      eof_p2_q <= eof_p1_q;
      if (vld_p1_q) data_p2_q <= sat(sum_p1);
    end
  end

  assign o_busy = (state_q == S_FLUSH);
  assign o_strb = vld_p2_q;
  assign o_data = data_p2_q;
  assign o_eof  = eof_p2_q;
  assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_filter2d_stream.sv
// Directed bench for filter2d_stream on an 8x8 frame with a scoreboard of
// expected pixels and trigger-to-output latencies.
module tb_filter2d_stream;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int SH = 4;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic              i_strb = 1'b0;
  logic [7:0]        i_data = '0;
  logic              i_coef_we = 1'b0;
  logic [3:0]        i_coef_addr = '0;
  logic signed [7:0] i_coef = '0;
  logic              o_busy, o_strb, o_eof, o_ovf;
  logic [7:0]        o_data;

  filter2d_stream #(.DW(8), .IMG_W(W), .IMG_H(H), .SHIFT(SH)) dut (
    .clk(clk), .n_reset(n_reset), .i_strb(i_strb), .i_data(i_data),
    .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef(i_coef),
    .o_busy(o_busy), .o_strb(o_strb), .o_data(o_data), .o_eof(o_eof), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       eof;
  } exp_t;

  exp_t sb_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b1;
  int   sh_k[9];
  int   img[N];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    int   el;
    #1;
    if (mon_en && o_strb) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++; $error("FAIL unexpected_out obs=%0d exp=none", o_data);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        assert (o_data === e.d) else begin
          errors++; $error("FAIL o_data obs=%0d exp=%0d", o_data, e.d);
        end
        checks++;
        assert (o_eof === e.eof) else begin
          errors++; $error("FAIL o_eof obs=%0b exp=%0b", o_eof, e.eof);
        end
      end
      if (lat_q.size() != 0) begin
        el = lat_q.pop_front();
        checks++;
        assert (cyc === el) else begin
          errors++; $error("FAIL latency obs_cycle=%0d exp_cycle=%0d", cyc, el);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_model();
    for (int k = 0; k < 9; k++) sh_k[k] = 0;
    sh_k[4] = 16;
  endtask

  task automatic push_expected(input int k[9]);
    exp_t e;
    int   s, v, rr, cc;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
              s += img[rr * W + cc] * k[(dr + 1) * 3 + dc + 1];
          end
        end
        v = s >>> SH;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        e.d   = v[7:0];
        e.eof = (r == H - 1) && (c == W - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic write_coef(input int a, input int v);
    i_coef_we   = 1'b1;
    i_coef_addr = a[3:0];
    i_coef      = v[7:0];
    tick();
    i_coef_we   = 1'b0;
    if (a < 9) sh_k[a] = v;
  endtask

  task automatic set_kernel(input int k[9]);
    for (int a = 0; a < 9; a++) write_coef(a, k[a]);
  endtask

  task automatic send_frame(input bit gaps, input int wr_at, input int wr_a, input int wr_v);
    int act[9];
    if (wr_at == 0 && wr_a < 9) sh_k[wr_a] = wr_v;
    act = sh_k;
    push_expected(act);
    for (int n = 0; n < N; n++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      i_strb = 1'b1;
      i_data = img[n][7:0];
      if (n == wr_at) begin
        i_coef_we   = 1'b1;
        i_coef_addr = wr_a[3:0];
        i_coef      = wr_v[7:0];
        if (n != 0 && wr_a < 9) sh_k[wr_a] = wr_v;
      end
      if (n >= W + 1) lat_q.push_back(cyc + 3);
      tick();
      i_strb    = 1'b0;
      i_coef_we = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 500 && sb_q.size() != 0; i++) tick();
    checks++;
    assert (sb_q.size() === 0) else begin
      errors++; $error("FAIL %s_count obs_left=%0d exp_left=0", tag, sb_q.size());
    end
    tick();
    checks++;
    assert (o_busy === 1'b0) else begin
      errors++; $error("FAIL %s_busy_after_eof obs=%0b exp=0", tag, o_busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; assert (o_strb === 1'b0) else begin errors++; $error("FAIL %s_strb obs=%0b exp=0", tag, o_strb); end
    checks++; assert (o_data === 8'd0) else begin errors++; $error("FAIL %s_data obs=%0d exp=0", tag, o_data); end
    checks++; assert (o_eof  === 1'b0) else begin errors++; $error("FAIL %s_eof obs=%0b exp=0", tag, o_eof); end
    checks++; assert (o_busy === 1'b0) else begin errors++; $error("FAIL %s_busy obs=%0b exp=0", tag, o_busy); end
    checks++; assert (o_ovf  === 1'b0) else begin errors++; $error("FAIL %s_ovf obs=%0b exp=0", tag, o_ovf); end
  endtask

  initial begin
    int kb[9];
    reset_model();
    n_reset = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    n_reset = 1'b1;
    tick();

    // Pass-through ramp with random gaps.
    for (int n = 0; n < N; n++) img[n] = n;
    send_frame(1'b1, -1, 0, 0);
    wait_done("ramp");

    // All-ones kernel scaled by 2^SHIFT on a constant image: 40 / 60 / 90.
    kb = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
    set_kernel(kb);
    for (int n = 0; n < N; n++) img[n] = 10;
    send_frame(1'b0, -1, 0, 0);
    wait_done("const");

    // Negative centre clamps to zero; out-of-range address is ignored.
    kb = '{0, 0, 0, 0, -1, 0, 0, 0, 0};
    set_kernel(kb);
    write_coef(12, 55);
    for (int n = 0; n < N; n++) img[n] = $urandom_range(0, 255);
    send_frame(1'b1, -1, 0, 0);
    wait_done("neg");

    // Upper saturation.
    kb = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
    set_kernel(kb);
    for (int n = 0; n < N; n++) img[n] = 255;
    send_frame(1'b0, -1, 0, 0);
    wait_done("sat");

    // Mid-frame write affects only the next frame; write with pixel 0 is included.
    kb = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    set_kernel(kb);
    for (int n = 0; n < N; n++) img[n] = $urandom_range(0, 255);
    send_frame(1'b1, 20, 4, 40);
    wait_done("midwr");
    send_frame(1'b0, -1, 0, 0);
    wait_done("newk");
    send_frame(1'b1, 0, 0, -8);
    wait_done("wr0");

    // Input during flush is dropped and latches o_ovf.
    for (int n = 0; n < N; n++) img[n] = $urandom_range(0, 255);
    send_frame(1'b0, -1, 0, 0);
    for (int i = 0; i < 20 && !o_busy; i++) tick();
    checks++;
    assert (o_busy === 1'b1) else begin errors++; $error("FAIL flush_busy obs=%0b exp=1", o_busy); end
    i_strb = 1'b1;
    i_data = 8'd200;
    repeat (3) tick();
    i_strb = 1'b0;
    checks++;
    assert (o_ovf === 1'b1) else begin errors++; $error("FAIL ovf_set obs=%0b exp=1", o_ovf); end
    wait_done("drop");
    repeat (10) tick();
    send_frame(1'b1, -1, 0, 0);
    wait_done("after_drop");
    checks++;
    assert (o_ovf === 1'b1) else begin errors++; $error("FAIL ovf_sticky obs=%0b exp=1", o_ovf); end

    // Reset mid-frame: abandon frame, kernel returns to pass-through.
    kb = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    set_kernel(kb);
    mon_en = 1'b0;
    for (int n = 0; n < 30; n++) begin
      i_strb = 1'b1;
      i_data = 8'($urandom_range(0, 255));
      tick();
    end
    i_strb  = 1'b0;
    n_reset = 1'b0;
    sb_q.delete();
    lat_q.delete();
    reset_model();
    #1;
    mon_en = 1'b1;
    check_reset_outputs("midreset");
    repeat (2) tick();
    n_reset = 1'b1;
    tick();
    for (int n = 0; n < N; n++) img[n] = $urandom_range(0, 255);
    send_frame(1'b1, -1, 0, 0);
    wait_done("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
